// File: rtl/fp_align_shifter.sv
// FPU add/sub pre-adder alignment: selects the larger-exponent operand and
// right-shifts the other mantissa iteratively, collecting guard/round/sticky.
module fp_align_shifter #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a_exp,
    input  logic [23:0] a_mant,
    input  logic [7:0]  b_exp,
    input  logic [23:0] b_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] big_mant,
    output logic [24:0] small_mant,
    output logic [7:0]  out_exp,
    output logic [2:0]  grs,
    output logic        swapped
);

    typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

    typedef struct packed {
        logic [7:0]  exp;
        logic [23:0] mant;
    } operand_t;

    localparam logic [4:0] STEP    = 5'(SHIFT_STEP);
    localparam logic [4:0] MAX_CNT = 5'd26;

    state_t      state_q, state_d;
    operand_t    a_q, b_q;
    operand_t    big_op, small_op;
    logic [23:0] big_mant_q;
    logic [7:0]  big_exp_q;
    logic        swapped_q;
    logic [4:0]  cnt_q;
    logic [26:0] ext_q;

    logic        a_ge_b;
    logic [7:0]  diff;
    logic [4:0]  cmp_cnt;
    logic [4:0]  step_k;
    logic [4:0]  cnt_next;
    logic [26:0] shift_mask;
    logic [26:0] ext_shr;
    logic [26:0] ext_next;

    // Equal exponents keep A as the big operand.
    assign a_ge_b   = a_q.exp >= b_q.exp;
    assign big_op   = a_ge_b ? a_q : b_q;
    assign small_op = a_ge_b ? b_q : a_q;
    assign diff     = big_op.exp - small_op.exp;
    assign cmp_cnt  = (diff >= 8'd26) ? MAX_CNT : diff[4:0];

    // Bits falling off the bottom fold into the sticky position, which is
    // never cleared, so sticky accumulates across all shift cycles.
    assign step_k     = (cnt_q < STEP) ? cnt_q : STEP;
    assign cnt_next   = cnt_q - step_k;
    assign shift_mask = ~({27{1'b1}} << step_k);
    assign ext_shr    = ext_q >> step_k;
    assign ext_next   = {ext_shr[26:1], ext_shr[0] | (|(ext_q & shift_mask))};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (in_valid) state_d = CMP;
            CMP:   state_d = (cmp_cnt != 5'd0) ? SHIFT : DONE;
            SHIFT: if (cnt_next == 5'd0) state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            big_mant_q <= '0;
            big_exp_q  <= '0;
            swapped_q  <= 1'b0;
            cnt_q      <= '0;
            ext_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q <= '{exp: a_exp, mant: a_mant};
                    b_q <= '{exp: b_exp, mant: b_mant};
                end
                CMP: begin
                    big_mant_q <= big_op.mant;
                    big_exp_q  <= big_op.exp;
                    swapped_q  <= ~a_ge_b;
                    cnt_q      <= cmp_cnt;
                    ext_q      <= {small_op.mant, 3'b000};
                end
                SHIFT: begin
                    ext_q <= ext_next;
                    cnt_q <= cnt_next;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign big_mant   = {1'b0, big_mant_q};
    assign small_mant = {1'b0, ext_q[26:3]};
    assign out_exp    = big_exp_q;
    assign grs        = ext_q[2:0];
    assign swapped    = swapped_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Directed bench for fp_align_shifter (SHIFT_STEP=4): values, latency,
// backpressure and mid-transaction reset.
module tb_fp_align_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_mant, b_mant;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] big_mant, small_mant;
    logic [7:0]  out_exp;
    logic [2:0]  grs;
    logic        swapped;

    int passed = 0;
    int total  = 0;
    int lat;

    fp_align_shifter #(.SHIFT_STEP(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_exp(a_exp), .a_mant(a_mant), .b_exp(b_exp), .b_mant(b_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .big_mant(big_mant), .small_mant(small_mant), .out_exp(out_exp),
        .grs(grs), .swapped(swapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Presents one operand pair and counts edges (accepting edge = 1)
    // until out_valid is seen; inputs change and outputs are sampled 1ns
    // after the rising edge.
    task automatic start(input logic [7:0] ae, input logic [23:0] am,
                         input logic [7:0] be, input logic [23:0] bm);
        a_exp = ae; a_mant = am; b_exp = be; b_mant = bm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run(input logic [7:0] ae, input logic [23:0] am,
                       input logic [7:0] be, input logic [23:0] bm, output int l);
        start(ae, am, be, bm);
        l = 1;
        while (!out_valid && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_exp = '0; a_mant = '0; b_exp = '0; b_mant = '0;
        #12;
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_small_mant", 32'(small_mant), 32'd0);
        check("rst_big_mant",   32'(big_mant),   32'd0);
        check("rst_out_exp",    32'(out_exp),    32'd0);
        check("rst_grs",        32'(grs),        32'd0);
        check("rst_swapped",    32'(swapped),    32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Equal exponents
        run(8'h85, 24'hC00000, 8'h85, 24'hA00000, lat);
        check("eq_latency",  32'(lat),        32'd2);
        check("eq_swapped",  32'(swapped),    32'd0);
        check("eq_big",      32'(big_mant),   32'h0C00000);
        check("eq_small",    32'(small_mant), 32'h0A00000);
        check("eq_grs",      32'(grs),        32'd0);
        check("eq_exp",      32'(out_exp),    32'h85);
        release_out();

        // B larger, diff 3
        run(8'h80, 24'h800000, 8'h83, 24'h800001, lat);
        check("bl_latency", 32'(lat),        32'd3);
        check("bl_swapped", 32'(swapped),    32'd1);
        check("bl_exp",     32'(out_exp),    32'h83);
        check("bl_big",     32'(big_mant),   32'h0800001);
        check("bl_small",   32'(small_mant), 32'h0100000);
        check("bl_grs",     32'(grs),        32'd0);

        // Backpressure: stay in DONE with in_valid toggling and new operands
        for (int i = 0; i < 3; i++) begin
            a_exp = 8'h10 + 8'(i); a_mant = 24'hFFFFFF; b_exp = 8'h90; b_mant = 24'h123456;
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid),  32'd1);
            check("bp_in_ready",  32'(in_ready),   32'd0);
            check("bp_small",     32'(small_mant), 32'h0100000);
            check("bp_big",       32'(big_mant),   32'h0800001);
            check("bp_exp",       32'(out_exp),    32'h83);
            check("bp_swapped",   32'(swapped),    32'd1);
        end
        in_valid = 1'b0;
        release_out();

        // Guard/round/sticky capture, diff 5
        run(8'h85, 24'h800000, 8'h80, 24'h80001F, lat);
        check("grs_latency", 32'(lat),        32'd4);
        check("grs_small",   32'(small_mant), 32'h0040000);
        check("grs_grs",     32'(grs),        32'b111);
        check("grs_swapped", 32'(swapped),    32'd0);
        check("grs_big",     32'(big_mant),   32'h0800000);
        release_out();

        // Saturation, diff 40
        run(8'h90, 24'h800000, 8'h68, 24'h800000, lat);
        check("sat_latency", 32'(lat),        32'd9);
        check("sat_small",   32'(small_mant), 32'd0);
        check("sat_grs",     32'(grs),        32'b001);
        check("sat_exp",     32'(out_exp),    32'h90);
        check("sat_big",     32'(big_mant),   32'h0800000);
        release_out();

        // Reset during the second SHIFT cycle of the diff-40 case
        start(8'h90, 24'h800000, 8'h68, 24'h800000);   // now in CMP
        @(posedge clk); #1;                             // first SHIFT cycle
        check("mid_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;                             // second SHIFT cycle
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 32'(out_valid),  32'd0);
        check("mrst_in_ready",  32'(in_ready),   32'd1);
        check("mrst_small",     32'(small_mant), 32'd0);
        check("mrst_grs",       32'(grs),        32'd0);
        check("mrst_exp",       32'(out_exp),    32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run(8'h85, 24'hC00000, 8'h85, 24'hA00000, lat);
        check("post_latency", 32'(lat),        32'd2);
        check("post_big",     32'(big_mant),   32'h0C00000);
        check("post_small",   32'(small_mant), 32'h0A00000);
        check("post_grs",     32'(grs),        32'd0);
        check("post_exp",     32'(out_exp),    32'h85);
        release_out();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fp_align_shifter.md
# fp_align_shifter

Pre-adder alignment stage of the FPU add/subtract path: it works in the opposite direction to the post-add normaliser. It takes two operands (8-bit exponent, 24-bit mantissa with hidden bit), selects the larger-exponent operand, and right-shifts the other mantissa by the exponent difference. The shift is iterative, at most SHIFT_STEP bits per cycle. Guard/round/sticky bits are collected for downstream rounding. Valid/ready handshakes are used on both sides, with one transaction in flight.

## Interface
- SHIFT_STEP, 4, maximum right-shift bits per SHIFT cycle; legal 1..26
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a_exp  input  8  operand A exponent
- a_mant  input  24  operand A mantissa, hidden bit at [23]
- b_exp  input  8  operand B exponent
- b_mant  input  24  operand B mantissa, hidden bit at [23]
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream accepts result
- big_mant  output  25  larger-exponent mantissa, [24]=0 carry headroom
- small_mant  output  25  aligned smaller mantissa, [24]=0
- out_exp  output  8  larger exponent (common exponent)
- grs  output  3  {guard, round, sticky} shifted out of small_mant
- swapped  output  1  1 when B was selected as big operand

## Operation
- States: IDLE, CMP, SHIFT, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready, register a_exp, a_mant, b_exp, b_mant, then go to CMP.
- CMP (always 1 cycle):
  - If a_exp >= b_exp: big=A, small=B, swapped=0.
  - Else: big=B, small=A, swapped=1.
  - Equal exponents select A regardless of mantissa.
  - diff = big_exp - small_exp (8-bit unsigned, never negative).
  - count = min(diff, 26).
  - ext (27 bits) = {small_mant, 3'b000}.
  - Next state: SHIFT if count != 0, else DONE.
- SHIFT: k = min(count, SHIFT_STEP).
  - ext <= (ext >> k), with ext[0] ORed with the OR of the k bits shifted out.
  - count <= count - k.
  - Go to DONE when the updated count is 0.
- Sticky is cumulative and never cleared within a transaction.
- Any diff >= 26 produces small_mant=0 and grs={0,0,|small_mant_in}.
- DONE: out_valid=1.
  - small_mant={1'b0, ext[26:3]}, grs=ext[2:0], big_mant={1'b0, big mantissa}, out_exp=big exponent.
  - Hold until out_ready, then go to IDLE.
- in_valid is ignored outside IDLE.
- Exponent 0 is treated as a plain value: no denormal special-casing. The hidden bit is supplied by upstream.

## Timing
- Reset (async, immediate): state=IDLE, out_valid=0, in_ready=1, big_mant=0, small_mant=0, out_exp=0, grs=0, swapped=0, internal count=0.
- Latency from the accepting edge to out_valid high is 2 + ceil(count/SHIFT_STEP) cycles.
  - With SHIFT_STEP=4: diff=0 gives 2 cycles; diff=26+ gives 9 cycles.
- Outputs are registered and stable while out_valid=1 and out_ready=0.
- After the out_valid & out_ready edge: out_valid=0 and in_ready=1 in the next cycle.
  - No same-cycle accept of new input; throughput is one transaction per (latency+1) cycles minimum.
- Reset asserted in any state aborts the transaction with no output and returns to IDLE. Outputs take their reset values.
- out_ready asserted outside DONE has no effect.

## Test plan
- Equal exponents: a_exp=0x85, a_mant=0xC00000, b_exp=0x85, b_mant=0xA00000.
  - Expect swapped=0, big_mant=0x0C00000, small_mant=0x0A00000, grs=000, out_exp=0x85.
  - out_valid 2 cycles after accept.
- B larger: a_exp=0x80, a_mant=0x800000, b_exp=0x83, b_mant=0x800001.
  - Expect swapped=1, out_exp=0x83, big_mant=0x0800001, small_mant=0x0100000, grs=000.
  - Latency 3.
- GRS capture: a_exp=0x85, a_mant=0x800000, b_exp=0x80, b_mant=0x80001F.
  - Expect small_mant=0x0040000, grs=111.
  - Latency 4 (two SHIFT cycles).
- Saturation: a_exp=0x90, a_mant=0x800000, b_exp=0x68, b_mant=0x800000 (diff=40).
  - Expect small_mant=0, grs=001.
  - Latency 9.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid with new operands.
  - Outputs unchanged and in_ready=0 throughout.
  - One cycle after the out_ready handshake, in_ready=1 and the next operand pair is accepted correctly.
- Reset mid-SHIFT: assert rst during the second SHIFT cycle of the diff=40 case.
  - out_valid=0 and in_ready=1 immediately.
  - A following equal-exponent transaction completes with the correct values.
